ped_signal_controller: RTL and testbench



---
 rtl/ped_signal_pkg.sv | 61 ++++++
 rtl/ped_signal_controller_phase_timer.sv | 31 +++
 rtl/ped_signal_controller.sv | 150 +++++++++++++++
 tb/tb_ped_signal_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ped_signal_pkg.sv
// Shared types and constants for the pedestrian-crossing phase sequencer.
// Lamp patterns are packed {car_red, car_yellow, car_green, ped_walk, ped_stop}.
package ped_signal_pkg;

    localparam int CNT_W = 7;

    typedef enum logic [2:0] {
        S_CAR_GREEN  = 3'd0,
        S_CAR_YELLOW = 3'd1,
        S_ALLRED1    = 3'd2,
        S_PED_WALK   = 3'd3,
        S_PED_FLASH  = 3'd4,
        S_ALLRED2    = 3'd5
    } state_t;

    typedef struct packed {
        logic car_red;
        logic car_yellow;
        logic car_green;
        logic ped_walk;
        logic ped_stop;
    } lamp_t;

    localparam lamp_t LAMP_GREEN  = lamp_t'(5'b00101);
    localparam lamp_t LAMP_YELLOW = lamp_t'(5'b01001);
    localparam lamp_t LAMP_ALLRED = lamp_t'(5'b10001);
    localparam lamp_t LAMP_WALK   = lamp_t'(5'b10010);
    // ped_walk in the flash phase is overridden by the blink flop
    localparam lamp_t LAMP_FLASH  = lamp_t'(5'b10000);

    function automatic state_t next_phase(input state_t s);
        state_t n;
        n = S_CAR_GREEN;
        unique case (s)
            S_CAR_GREEN:  n = S_CAR_YELLOW;
            S_CAR_YELLOW: n = S_ALLRED1;
            S_ALLRED1:    n = S_PED_WALK;
            S_PED_WALK:   n = S_PED_FLASH;
            S_PED_FLASH:  n = S_ALLRED2;
            S_ALLRED2:    n = S_CAR_GREEN;
            default:      n = S_CAR_GREEN;
        endcase
        return n;
    endfunction

    function automatic lamp_t lamp_of(input state_t s);
        lamp_t l;
        l = LAMP_ALLRED;
        unique case (s)
            S_CAR_GREEN:  l = LAMP_GREEN;
            S_CAR_YELLOW: l = LAMP_YELLOW;
            S_ALLRED1:    l = LAMP_ALLRED;
            S_PED_WALK:   l = LAMP_WALK;
            S_PED_FLASH:  l = LAMP_FLASH;
            S_ALLRED2:    l = LAMP_ALLRED;
            default:      l = LAMP_ALLRED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/ped_signal_controller_phase_timer.sv
// Phase countdown: load has priority, otherwise decrement on tick while above 1.
// Reaching 1 on a tick raises expire; the sequencer decides what to load next.
module phase_timer
    import ped_signal_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = 7'd10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             expire,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt > CNT_W'(1))) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = tick && (cnt == CNT_W'(1));
    assign zero   = (cnt == '0);

endmodule

// File: rtl/ped_signal_controller.sv
// Pedestrian-crossing phase sequencer: request latch, phase FSM, walk blink.
// Optional PED_BTN_SYNC_EN adds a 2-flop synchroniser and rising-edge detect on ped_req.
module ped_signal_controller
    import ped_signal_pkg::*;
#(
    parameter int MIN_GREEN = 10,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 15,
    parameter int FLASH_T   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ped_req,
    output logic             car_red,
    output logic             car_yellow,
    output logic             car_green,
    output logic             ped_walk,
    output logic             ped_stop,
    output logic             req_pending,
    output logic [CNT_W-1:0] remain
);

    localparam logic [CNT_W-1:0] MG_V = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] YT_V = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] AR_V = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] WK_V = CNT_W'(WALK_T);
    localparam logic [CNT_W-1:0] FL_V = CNT_W'(FLASH_T);

    function automatic logic [CNT_W-1:0] dur(input state_t s);
        logic [CNT_W-1:0] d;
        d = AR_V;
        unique case (s)
            S_CAR_GREEN:  d = MG_V;
            S_CAR_YELLOW: d = YT_V;
            S_ALLRED1:    d = AR_V;
            S_PED_WALK:   d = WK_V;
            S_PED_FLASH:  d = FL_V;
            S_ALLRED2:    d = AR_V;
            default:      d = AR_V;
        endcase
        return d;
    endfunction

    state_t           state;
    state_t           state_n;
    logic             blink;
    logic             req_evt;
    logic             ld;
    logic [CNT_W-1:0] ld_val;
    logic [CNT_W-1:0] cnt;
    logic             expire;
    logic             zero;
    lamp_t            lamp;

`ifdef PED_BTN_SYNC_EN
    logic [2:0] btn_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sync <= '0;
        end else begin
            btn_sync <= {btn_sync[1:0], ped_req};
        end
    end

    // one event per press, two flops after the pin plus the latch edge
    assign req_evt = btn_sync[1] & ~btn_sync[2];
`else
    assign req_evt = ped_req;
`endif

    phase_timer #(
        .RST_VAL (MG_V)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (ld),
        .load_val (ld_val),
        .cnt      (cnt),
        .expire   (expire),
        .zero     (zero)
    );

    always_comb begin
        state_n = state;
        ld      = 1'b0;
        ld_val  = '0;
        unique case (state)
            S_CAR_GREEN: begin
                // green parks at zero until a request arrives
                if ((expire || (tick && zero)) && req_pending) begin
                    state_n = S_CAR_YELLOW;
                    ld      = 1'b1;
                    ld_val  = YT_V;
                end else if (expire) begin
                    ld      = 1'b1;
                    ld_val  = '0;
                end
            end
            default: begin
                if (expire) begin
                    state_n = next_phase(state);
                    ld      = 1'b1;
                    ld_val  = dur(state_n);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_CAR_GREEN;
            req_pending <= 1'b0;
            blink       <= 1'b0;
        end else begin
            state <= state_n;

            if (state_n == S_PED_WALK && state != S_PED_WALK) begin
                req_pending <= 1'b0;
            end else if (req_evt && state != S_PED_WALK
                         && state != S_PED_FLASH) begin
                req_pending <= 1'b1;
            end

            if (state_n == S_PED_FLASH && state != S_PED_FLASH) begin
                blink <= 1'b1;
            end else if (state == S_PED_FLASH && tick) begin
                blink <= ~blink;
            end
        end
    end

    always_comb begin
        lamp = lamp_of(state);
        if (state == S_PED_FLASH) begin
            lamp.ped_walk = blink;
        end
    end

    assign car_red    = lamp.car_red;
    assign car_yellow = lamp.car_yellow;
    assign car_green  = lamp.car_green;
    assign ped_walk   = lamp.ped_walk;
    assign ped_stop   = lamp.ped_stop;
    assign remain     = cnt;

endmodule

// File: tb/tb_ped_signal_controller.sv
// Directed bench for ped_signal_controller with short phase durations.
// Lamp vectors are {car_red, car_yellow, car_green, ped_walk, ped_stop}.
module tb_ped_signal_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       car_red;
    logic       car_yellow;
    logic       car_green;
    logic       ped_walk;
    logic       ped_stop;
    logic       req_pending;
    logic [6:0] remain;
    logic [4:0] lamps;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [4:0] L_G  = 5'b00101;
    localparam logic [4:0] L_Y  = 5'b01001;
    localparam logic [4:0] L_AR = 5'b10001;
    localparam logic [4:0] L_WK = 5'b10010;
    localparam logic [4:0] L_FO = 5'b10000;

    assign lamps = {car_red, car_yellow, car_green, ped_walk, ped_stop};

    ped_signal_controller #(
        .MIN_GREEN (5),
        .YELLOW_T  (3),
        .ALLRED_T  (2),
        .WALK_T    (8),
        .FLASH_T   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .ped_req     (ped_req),
        .car_red     (car_red),
        .car_yellow  (car_yellow),
        .car_green   (car_green),
        .ped_walk    (ped_walk),
        .ped_stop    (ped_stop),
        .req_pending (req_pending),
        .remain      (remain)
    );

    always #5 clk = ~clk;

    task automatic clk_cyc(input logic t, input logic p);
        tick    = t;
        ped_req = p;
        @(posedge clk);
        #1;
        tick    = 1'b0;
        ped_req = 1'b0;
    endtask

    task automatic tick_period(input logic p);
        clk_cyc(1'b1, p);
        repeat (3) clk_cyc(1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_period(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clk_cyc(1'b0, 1'b0);
        clk_cyc(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({req_pending, lamps, remain} !== {1'b0, L_G, 7'd5}) begin
            n_fail++;
            $display("FAIL reset: got req=%b lamps=%b remain=%0d, want req=0 lamps=%b remain=5",
                     req_pending, lamps, remain, L_G);
        end
    endtask

    task automatic test_idle_green();
        logic [6:0] exp_r;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            tick_period(1'b0);
            exp_r = (k < 5) ? 7'(5 - k) : 7'd0;
            n_checks++;
            if ({req_pending, lamps, remain} !== {1'b0, L_G, exp_r}) begin
                n_fail++;
                $display("FAIL idle_green tick %0d: got lamps=%b remain=%0d, want lamps=%b remain=%0d",
                         k, lamps, remain, L_G, exp_r);
            end
        end
    endtask

    task automatic test_press_cycle();
        logic [12:0] tbl [20];
        tbl = '{
            {1'b1, L_Y,  7'd3}, {1'b1, L_Y,  7'd2}, {1'b1, L_Y,  7'd1},
            {1'b1, L_AR, 7'd2}, {1'b1, L_AR, 7'd1},
            {1'b0, L_WK, 7'd8}, {1'b0, L_WK, 7'd7}, {1'b0, L_WK, 7'd6},
            {1'b0, L_WK, 7'd5}, {1'b0, L_WK, 7'd4}, {1'b0, L_WK, 7'd3},
            {1'b0, L_WK, 7'd2}, {1'b0, L_WK, 7'd1},
            {1'b0, L_WK, 7'd4}, {1'b0, L_FO, 7'd3},
            {1'b0, L_WK, 7'd2}, {1'b0, L_FO, 7'd1},
            {1'b0, L_AR, 7'd2}, {1'b0, L_AR, 7'd1},
            {1'b0, L_G,  7'd5}
        };
        do_reset();
        ticks(20);
        clk_cyc(1'b0, 1'b1);
        n_checks++;
        if ({req_pending, lamps, remain} !== {1'b1, L_G, 7'd0}) begin
            n_fail++;
            $display("FAIL press_latch: got req=%b lamps=%b remain=%0d, want req=1 lamps=%b remain=0",
                     req_pending, lamps, remain, L_G);
        end
        for (int i = 0; i < 20; i++) begin
            tick_period(1'b0);
            n_checks++;
            if ({req_pending, lamps, remain} !== tbl[i]) begin
                n_fail++;
                $display("FAIL press_cycle step %0d: got %b_%b_%0d, want %b_%b_%0d",
                         i + 1, req_pending, lamps, remain,
                         tbl[i][12], tbl[i][11:7], tbl[i][6:0]);
            end
        end
    endtask

    task automatic test_min_green();
        do_reset();
        tick_period(1'b0);
        tick_period(1'b1);
        n_checks++;
        if ({req_pending, lamps, remain} !== {1'b1, L_G, 7'd3}) begin
            n_fail++;
            $display("FAIL tick_and_req: got req=%b lamps=%b remain=%0d, want req=1 lamps=%b remain=3",
                     req_pending, lamps, remain, L_G);
        end
        ticks(2);
        n_checks++;
        if ({lamps, remain} !== {L_G, 7'd1}) begin
            n_fail++;
            $display("FAIL min_green_tick4: got lamps=%b remain=%0d, want lamps=%b remain=1",
                     lamps, remain, L_G);
        end
        ticks(1);
        n_checks++;
        if ({lamps, remain} !== {L_Y, 7'd3}) begin
            n_fail++;
            $display("FAIL min_green_tick5: got lamps=%b remain=%0d, want lamps=%b remain=3",
                     lamps, remain, L_Y);
        end
    endtask

    task automatic test_drop_in_walk();
        do_reset();
        clk_cyc(1'b0, 1'b1);
        ticks(10);
        clk_cyc(1'b0, 1'b1);
        n_checks++;
        if ({req_pending, lamps, remain} !== {1'b0, L_WK, 7'd8}) begin
            n_fail++;
            $display("FAIL walk_drop: got req=%b lamps=%b remain=%0d, want req=0 lamps=%b remain=8",
                     req_pending, lamps, remain, L_WK);
        end
        ticks(14);
        n_checks++;
        if ({req_pending, lamps, remain} !== {1'b0, L_G, 7'd5}) begin
            n_fail++;
            $display("FAIL walk_drop_green: got req=%b lamps=%b remain=%0d, want req=0 lamps=%b remain=5",
                     req_pending, lamps, remain, L_G);
        end
        ticks(10);
        n_checks++;
        if ({req_pending, lamps, remain} !== {1'b0, L_G, 7'd0}) begin
            n_fail++;
            $display("FAIL walk_drop_hold: got req=%b lamps=%b remain=%0d, want req=0 lamps=%b remain=0",
                     req_pending, lamps, remain, L_G);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clk_cyc(1'b0, 1'b1);
        ticks(22);
        clk_cyc(1'b0, 1'b1);
        n_checks++;
        if ({req_pending, lamps, remain} !== {1'b1, L_AR, 7'd2}) begin
            n_fail++;
            $display("FAIL allred2_press: got req=%b lamps=%b remain=%0d, want req=1 lamps=%b remain=2",
                     req_pending, lamps, remain, L_AR);
        end
        ticks(2);
        n_checks++;
        if ({req_pending, lamps, remain} !== {1'b1, L_G, 7'd5}) begin
            n_fail++;
            $display("FAIL b2b_green: got req=%b lamps=%b remain=%0d, want req=1 lamps=%b remain=5",
                     req_pending, lamps, remain, L_G);
        end
        ticks(4);
        n_checks++;
        if ({lamps, remain} !== {L_G, 7'd1}) begin
            n_fail++;
            $display("FAIL b2b_green4: got lamps=%b remain=%0d, want lamps=%b remain=1",
                     lamps, remain, L_G);
        end
        ticks(1);
        n_checks++;
        if ({lamps, remain} !== {L_Y, 7'd3}) begin
            n_fail++;
            $display("FAIL b2b_yellow: got lamps=%b remain=%0d, want lamps=%b remain=3",
                     lamps, remain, L_Y);
        end
    endtask

    task automatic test_reset_in_walk();
        do_reset();
        clk_cyc(1'b0, 1'b1);
        ticks(14);
        n_checks++;
        if ({lamps, remain} !== {L_WK, 7'd4}) begin
            n_fail++;
            $display("FAIL walk_pre_reset: got lamps=%b remain=%0d, want lamps=%b remain=4",
                     lamps, remain, L_WK);
        end
        rst = 1'b1;
        clk_cyc(1'b1, 1'b1);
        rst = 1'b0;
        n_checks++;
        if ({req_pending, lamps, remain} !== {1'b0, L_G, 7'd5}) begin
            n_fail++;
            $display("FAIL walk_reset: got req=%b lamps=%b remain=%0d, want req=0 lamps=%b remain=5",
                     req_pending, lamps, remain, L_G);
        end
    endtask

    task automatic test_button_sync();
        logic exp_q;
        do_reset();
`ifdef PED_BTN_SYNC_EN
        ped_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            exp_q = (k >= 3);
            n_checks++;
            if (req_pending !== exp_q) begin
                n_fail++;
                $display("FAIL btn_sync edge %0d: got req=%b, want %b",
                         k, req_pending, exp_q);
            end
        end
        ped_req = 1'b0;
`else
        ped_req = 1'b1;
        @(posedge clk);
        #1;
        ped_req = 1'b0;
        exp_q = 1'b1;
        n_checks++;
        if (req_pending !== exp_q) begin
            n_fail++;
            $display("FAIL btn_level: got req=%b, want %b", req_pending, exp_q);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_idle_green();
        test_press_cycle();
        test_min_green();
        test_drop_in_walk();
        test_back_to_back();
        test_reset_in_walk();
        test_button_sync();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
